// File: rtl/type_enums.sv
// rtl/type_enums.sv - shared ALU operation and branch kind encodings
package type_enums;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_t;

    typedef enum logic [3:0] {
        BR_NONE = 4'd0,
        BR_EQ   = 4'd1,
        BR_NE   = 4'd2,
        BR_LT   = 4'd3,
        BR_GE   = 4'd4,
        BR_LTU  = 4'd5,
        BR_GEU  = 4'd6,
        BR_JAL  = 4'd7,
        BR_JALR = 4'd8
    } br_t;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational RV32I integer ALU with zero flag
import type_enums::*;

module alu #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  alu_t             op,
    output logic [WIDTH-1:0] out,
    output logic             out_is_zero
);

    localparam int SHW = $clog2(WIDTH);

    logic [SHW-1:0] shamt;

    assign shamt = op_b[SHW-1:0];

    always_comb begin
        out = '0;
        case (op)
            ALU_ADD:  out = op_a + op_b;
            ALU_SUB:  out = op_a - op_b;
            ALU_SLL:  out = op_a << shamt;
            ALU_SLT:  out = {{(WIDTH-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            ALU_SLTU: out = {{(WIDTH-1){1'b0}}, op_a < op_b};
            ALU_XOR:  out = op_a ^ op_b;
            ALU_SRL:  out = op_a >> shamt;
            ALU_SRA:  out = $unsigned($signed(op_a) >>> shamt);
            ALU_OR:   out = op_a | op_b;
            ALU_AND:  out = op_a & op_b;
            default:  out = '0;
        endcase
    end

    assign out_is_zero = (out == '0);

endmodule

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - RV32I execute stage: bypass, ALU, branch resolve, EX/MEM register
import type_enums::*;

module ex_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_pc,
    input  logic [WIDTH-1:0] in_rs1_val,
    input  logic [WIDTH-1:0] in_rs2_val,
    input  logic [WIDTH-1:0] in_imm,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [4:0]       in_rd,
    input  alu_t             in_alu_op,
    input  logic             in_src_a_pc,
    input  logic             in_src_b_imm,
    input  br_t              in_br,
    input  logic             in_reg_write,
    input  logic             wb_fwd_valid,
    input  logic [4:0]       wb_fwd_rd,
    input  logic [WIDTH-1:0] wb_fwd_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [WIDTH-1:0] out_store_data,
    output logic [4:0]       out_rd,
    output logic             out_reg_write,
    output logic             redirect_valid,
    output logic [WIDTH-1:0] redirect_pc
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_result_q, out_result_d;
    logic [WIDTH-1:0] out_store_data_q, out_store_data_d;
    logic [4:0]       out_rd_q, out_rd_d;
    logic             out_reg_write_q, out_reg_write_d;
    logic             redirect_valid_q, redirect_valid_d;
    logic [WIDTH-1:0] redirect_pc_q, redirect_pc_d;

    logic [WIDTH-1:0] rs1_fwd, rs2_fwd, op_a, op_b;
    logic [WIDTH-1:0] alu_out, br_target, link_addr, target, result;
    logic             alu_zero, taken, capture;

    // EX/MEM wins over WB because it holds the younger write; x0 is never bypassed.
    function automatic logic [WIDTH-1:0] bypass(
        input logic [4:0]       rs,
        input logic [WIDTH-1:0] rf_val,
        input logic             exm_hit_en,
        input logic [4:0]       exm_rd,
        input logic [WIDTH-1:0] exm_val,
        input logic             wb_en,
        input logic [4:0]       wb_rd,
        input logic [WIDTH-1:0] wb_val
    );
        if (exm_hit_en && exm_rd == rs && rs != 5'd0) return exm_val;
        else if (wb_en && wb_rd == rs && rs != 5'd0) return wb_val;
        else return rf_val;
    endfunction

    assign rs1_fwd = bypass(in_rs1, in_rs1_val, out_valid_q && out_reg_write_q, out_rd_q,
                            out_result_q, wb_fwd_valid, wb_fwd_rd, wb_fwd_data);
    assign rs2_fwd = bypass(in_rs2, in_rs2_val, out_valid_q && out_reg_write_q, out_rd_q,
                            out_result_q, wb_fwd_valid, wb_fwd_rd, wb_fwd_data);

    assign op_a = in_src_a_pc  ? in_pc  : rs1_fwd;
    assign op_b = in_src_b_imm ? in_imm : rs2_fwd;

    alu #(.WIDTH(WIDTH)) u_alu (
        .op_a        (op_a),
        .op_b        (op_b),
        .op          (in_alu_op),
        .out         (alu_out),
        .out_is_zero (alu_zero)
    );

    assign br_target = in_pc + in_imm;
    assign link_addr = in_pc + WIDTH'(4);
    assign target    = (in_br == BR_JALR) ? {alu_out[WIDTH-1:1], 1'b0} : br_target;
    assign result    = (in_br == BR_JAL || in_br == BR_JALR) ? link_addr : alu_out;

    always_comb begin
        taken = 1'b0;
        case (in_br)
            BR_EQ, BR_GE, BR_GEU:  taken = alu_zero;
            BR_NE, BR_LT, BR_LTU:  taken = !alu_zero;
            BR_JAL, BR_JALR:       taken = 1'b1;
            default:               taken = 1'b0;
        endcase
    end

    assign in_ready = !out_valid_q || out_ready || flush;
    assign capture  = in_valid && in_ready && !flush;

    always_comb begin
        out_valid_d      = out_valid_q;
        out_result_d     = out_result_q;
        out_store_data_d = out_store_data_q;
        out_rd_d         = out_rd_q;
        out_reg_write_d  = out_reg_write_q;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        if (capture) begin
            out_valid_d      = 1'b1;
            out_result_d     = result;
            out_store_data_d = rs2_fwd;
            out_rd_d         = in_rd;
            out_reg_write_d  = in_reg_write;
            redirect_valid_d = taken;
            redirect_pc_d    = target;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q      <= 1'b0;
            out_result_q     <= '0;
            out_store_data_q <= '0;
            out_rd_q         <= '0;
            out_reg_write_q  <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            out_valid_q      <= out_valid_d;
            out_result_q     <= out_result_d;
            out_store_data_q <= out_store_data_d;
            out_rd_q         <= out_rd_d;
            out_reg_write_q  <= out_reg_write_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign out_result     = out_result_q;
    assign out_store_data = out_store_data_q;
    assign out_rd         = out_rd_q;
    assign out_reg_write  = out_reg_write_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - directed self-checking bench for ex_stage
import type_enums::*;

module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [31:0] in_pc, in_rs1_val, in_rs2_val, in_imm;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    alu_t        in_alu_op;
    logic        in_src_a_pc, in_src_b_imm, in_reg_write;
    br_t         in_br;
    logic        wb_fwd_valid;
    logic [4:0]  wb_fwd_rd;
    logic [31:0] wb_fwd_data;
    logic        flush, out_valid, out_ready;
    logic [31:0] out_result, out_store_data, redirect_pc;
    logic [4:0]  out_rd;
    logic        out_reg_write, redirect_valid;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ex_stage #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_imm(in_imm),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_alu_op(in_alu_op),
        .in_src_a_pc(in_src_a_pc), .in_src_b_imm(in_src_b_imm), .in_br(in_br),
        .in_reg_write(in_reg_write), .wb_fwd_valid(wb_fwd_valid), .wb_fwd_rd(wb_fwd_rd),
        .wb_fwd_data(wb_fwd_data), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_store_data(out_store_data), .out_rd(out_rd),
        .out_reg_write(out_reg_write), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic [31:0] v1, input logic [31:0] v2,
                         input logic [31:0] imm, input alu_t op, input logic apc,
                         input logic bimm, input br_t br, input logic rw);
        in_valid = 1'b1; in_pc = pc; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
        in_rs1_val = v1; in_rs2_val = v2; in_imm = imm; in_alu_op = op;
        in_src_a_pc = apc; in_src_b_imm = bimm; in_br = br; in_reg_write = rw;
    endtask

    initial begin
        rst_n = 1'b0; out_ready = 1'b1; flush = 1'b0;
        in_valid = 1'b0; in_pc = '0; in_rs1_val = '0; in_rs2_val = '0; in_imm = '0;
        in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_alu_op = ALU_ADD;
        in_src_a_pc = 1'b0; in_src_b_imm = 1'b0; in_br = BR_NONE; in_reg_write = 1'b0;
        wb_fwd_valid = 1'b0; wb_fwd_rd = '0; wb_fwd_data = '0;
        #12;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // ADD x3 = x1 + x2
        issue(32'h0, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, ALU_ADD, 1'b0, 1'b0, BR_NONE, 1'b1);
        step();
        chk("add_valid", {31'd0, out_valid}, 32'd1);
        chk("add_result", out_result, 32'd12);
        chk("add_rd", {27'd0, out_rd}, 32'd3);
        chk("add_no_redirect", {31'd0, redirect_valid}, 32'd0);

        // ADDI x1, x0, 10 then ADD x2, x1, x1 with stale RF and a competing WB value
        issue(32'h4, 5'd0, 5'd0, 5'd1, 32'd0, 32'd0, 32'd10, ALU_ADD, 1'b0, 1'b1, BR_NONE, 1'b1);
        step();
        chk("addi_result", out_result, 32'd10);
        issue(32'h8, 5'd1, 5'd1, 5'd2, 32'd0, 32'd0, 32'd0, ALU_ADD, 1'b0, 1'b0, BR_NONE, 1'b1);
        wb_fwd_valid = 1'b1; wb_fwd_rd = 5'd1; wb_fwd_data = 32'd9;
        step();
        chk("exmem_bypass_result", out_result, 32'd20);
        chk("exmem_bypass_store", out_store_data, 32'd10);

        issue(32'hC, 5'd1, 5'd1, 5'd4, 32'd0, 32'd0, 32'd0, ALU_ADD, 1'b0, 1'b0, BR_NONE, 1'b1);
        step();
        chk("wb_bypass_result", out_result, 32'd18);

        // x0 destination and sources are never bypassed
        wb_fwd_valid = 1'b0;
        issue(32'h10, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd5, ALU_ADD, 1'b0, 1'b1, BR_NONE, 1'b1);
        step();
        chk("x0_write_result", out_result, 32'd5);
        wb_fwd_valid = 1'b1; wb_fwd_rd = 5'd0; wb_fwd_data = 32'd77;
        issue(32'h14, 5'd0, 5'd0, 5'd5, 32'd0, 32'd0, 32'd0, ALU_ADD, 1'b0, 1'b0, BR_NONE, 1'b1);
        step();
        chk("x0_no_forward", out_result, 32'd0);
        wb_fwd_valid = 1'b0;

        // BEQ taken, then one-cycle pulse check
        issue(32'h100, 5'd6, 5'd7, 5'd0, 32'h55, 32'h55, 32'h20, ALU_SUB, 1'b0, 1'b0, BR_EQ, 1'b0);
        step();
        chk("beq_taken_pulse", {31'd0, redirect_valid}, 32'd1);
        chk("beq_target", redirect_pc, 32'h120);
        in_valid = 1'b0;
        step();
        chk("beq_pulse_one_cycle", {31'd0, redirect_valid}, 32'd0);
        chk("drain_out_valid", {31'd0, out_valid}, 32'd0);

        issue(32'h100, 5'd6, 5'd7, 5'd0, 32'h55, 32'h56, 32'h20, ALU_SUB, 1'b0, 1'b0, BR_EQ, 1'b0);
        step();
        chk("beq_not_taken", {31'd0, redirect_valid}, 32'd0);
        chk("beq_nt_valid", {31'd0, out_valid}, 32'd1);

        // BLT signed: -1 < 1, negative offset
        issue(32'h300, 5'd6, 5'd7, 5'd0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF0, ALU_SLT, 1'b0, 1'b0, BR_LT, 1'b0);
        step();
        chk("blt_taken", {31'd0, redirect_valid}, 32'd1);
        chk("blt_target", redirect_pc, 32'h2F0);

        // JALR clears bit 0 of the target
        issue(32'h200, 5'd8, 5'd0, 5'd1, 32'h1003, 32'd0, 32'd4, ALU_ADD, 1'b0, 1'b1, BR_JALR, 1'b1);
        step();
        chk("jalr_redirect", {31'd0, redirect_valid}, 32'd1);
        chk("jalr_target", redirect_pc, 32'h1006);
        chk("jalr_link", out_result, 32'h204);

        // JAL with PC wrap-around
        issue(32'hFFFF_FFFC, 5'd0, 5'd0, 5'd1, 32'd0, 32'd0, 32'd8, ALU_ADD, 1'b1, 1'b1, BR_JAL, 1'b1);
        step();
        chk("jal_wrap_target", redirect_pc, 32'h4);
        chk("jal_wrap_link", out_result, 32'h0);

        // Stall for three cycles with a pending beat
        issue(32'h20, 5'd10, 5'd11, 5'd3, 32'd5, 32'd7, 32'd0, ALU_ADD, 1'b0, 1'b0, BR_NONE, 1'b1);
        step();
        chk("pre_stall_result", out_result, 32'd12);
        out_ready = 1'b0;
        issue(32'h24, 5'd12, 5'd13, 5'd9, 32'd100, 32'd1, 32'd0, ALU_ADD, 1'b0, 1'b0, BR_NONE, 1'b1);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
            step();
            chk("stall_result_hold", out_result, 32'd12);
            chk("stall_rd_hold", {27'd0, out_rd}, 32'd3);
            chk("stall_valid_hold", {31'd0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        #1;
        chk("release_in_ready", {31'd0, in_ready}, 32'd1);
        step();
        chk("release_next_result", out_result, 32'd101);
        chk("release_next_rd", {27'd0, out_rd}, 32'd9);
        chk("release_valid", {31'd0, out_valid}, 32'd1);

        // Flush during stall drops the beat, keeps EX/MEM
        out_ready = 1'b0;
        flush = 1'b1;
        issue(32'h28, 5'd12, 5'd13, 5'd4, 32'd2, 32'd2, 32'd0, ALU_ADD, 1'b0, 1'b0, BR_NONE, 1'b1);
        #1;
        chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
        step();
        chk("flush_valid_kept", {31'd0, out_valid}, 32'd1);
        chk("flush_result_kept", out_result, 32'd101);
        flush = 1'b0;

        // Capture a JAL, then reset asynchronously mid-stall
        out_ready = 1'b1;
        issue(32'h40, 5'd0, 5'd0, 5'd1, 32'd0, 32'd0, 32'h10, ALU_ADD, 1'b1, 1'b1, BR_JAL, 1'b1);
        step();
        chk("jal_pre_reset", {31'd0, redirect_valid}, 32'd1);
        out_ready = 1'b0;
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("async_rst_redirect", {31'd0, redirect_valid}, 32'd0);
        chk("async_rst_redirect_pc", redirect_pc, 32'd0);
        chk("async_rst_result", out_result, 32'd0);
        step();
        rst_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
